// File: rtl/alu_stream_pkg.sv
// Shared definitions for the streaming ALU: opcodes, FSM states and flag bit positions.
package alu_stream_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 in_clock,
    input  logic                 in_reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     lhs,
    input  logic [WIDTH-1:0]     rhs,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    // product is the accumulator including the current iteration, so it is final while done=1
    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == LAST);
    assign busy    = busy_q;
    assign product = acc_d;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, lhs};
            mplier_q <= rhs;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU with valid/ready on both sides, registered result and flags, iterative multiply.
// Handshake: a transfer happens on a rising edge where valid && ready; outputs hold until taken.
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              in_clock,
    input  logic              in_reset_n,
    input  logic              in_valid,
    output logic              out_in_ready,
    input  logic [WIDTH-1:0]  in_lhs,
    input  logic [WIDTH-1:0]  in_rhs,
    input  logic [2:0]        in_function,
    output logic              out_valid,
    input  logic              in_out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_overflow,
    output logic [1:0]        out_dbg_state
);

    localparam int SHW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic [WIDTH:0]      sum, diff;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_carry, alu_ovf;
    logic                accept, is_mul;
    logic                mul_busy, mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    assign sum  = {1'b0, in_lhs} + {1'b0, in_rhs};
    assign diff = {1'b0, in_lhs} - {1'b0, in_rhs};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (in_function)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (in_lhs[WIDTH-1] == in_rhs[WIDTH-1]) && (sum[WIDTH-1] != in_lhs[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (in_lhs[WIDTH-1] != in_rhs[WIDTH-1]) && (diff[WIDTH-1] != in_lhs[WIDTH-1]);
            end
            OP_AND: alu_res = in_lhs & in_rhs;
            OP_OR:  alu_res = in_lhs | in_rhs;
            OP_XOR: alu_res = in_lhs ^ in_rhs;
            // the whole rhs is the shift amount; anything at or past WIDTH clears the result
            OP_SHL: alu_res = (in_rhs >= W_VAL) ? '0 : (in_lhs << in_rhs[SHW-1:0]);
            OP_SHR: alu_res = (in_rhs >= W_VAL) ? '0 : (in_lhs >> in_rhs[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    assign out_in_ready = !mul_busy &&
                          ((state_q == ST_IDLE) || ((state_q == ST_DONE) && in_out_ready));
    assign accept       = in_valid && out_in_ready;
    assign is_mul       = (in_function == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .start      (accept && is_mul),
        .lhs        (in_lhs),
        .rhs        (in_rhs),
        .busy       (mul_busy),
        .done       (mul_done),
        .product    (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)            state_d = is_mul ? ST_MUL : ST_DONE;
                else if (in_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && !is_mul) begin
            result_d            = alu_res;
            flags_d[FLAG_ZERO]  = (alu_res == '0);
            flags_d[FLAG_CARRY] = alu_carry;
            flags_d[FLAG_OVF]   = alu_ovf;
        end else if ((state_q == ST_MUL) && mul_done) begin
            result_d            = mul_product[WIDTH-1:0];
            flags_d[FLAG_ZERO]  = (mul_product[WIDTH-1:0] == '0);
            flags_d[FLAG_CARRY] = 1'b0;
            flags_d[FLAG_OVF]   = (mul_product[2*WIDTH-1:WIDTH] != '0);
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid     = (state_q == ST_DONE);
    assign out_result    = result_q;
    assign out_zero      = flags_q[FLAG_ZERO];
    assign out_carry     = flags_q[FLAG_CARRY];
    assign out_overflow  = flags_q[FLAG_OVF];
    assign out_dbg_state = state_q;

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream (WIDTH=8): directed cases, backpressure, streaming, random, reset abort.
module tb_alu_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_in_ready;
    logic [7:0] in_lhs;
    logic [7:0] in_rhs;
    logic [2:0] in_function;
    logic       out_valid;
    logic       sink_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_carry;
    logic       out_overflow;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    bit rand_sink = 0;

    // expected {overflow, carry, zero, result[7:0]}
    logic [10:0] exp_q[$];

    alu_stream #(.WIDTH(8)) dut (
        .in_clock      (clk),
        .in_reset_n    (rst_n),
        .in_valid      (in_valid),
        .out_in_ready  (out_in_ready),
        .in_lhs        (in_lhs),
        .in_rhs        (in_rhs),
        .in_function   (in_function),
        .out_valid     (out_valid),
        .in_out_ready  (sink_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_carry     (out_carry),
        .out_overflow  (out_overflow),
        .out_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] got_bits();
        return {out_overflow, out_carry, out_zero, out_result};
    endfunction

    // reference model in plain integer arithmetic
    function automatic logic [10:0] model(input logic [2:0] op, input int a, input int b);
        int r;
        bit c;
        bit o;
        r = 0; c = 0; o = 0;
        case (op)
            3'd0: begin
                r = a + b; c = (r > 255); r = r & 255;
                o = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
            end
            3'd1: begin
                c = (a < b); r = (a - b) & 255;
                o = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (b >= 8) ? 0 : ((a << b) & 255);
            3'd6: r = (b >= 8) ? 0 : (a >> b);
            default: begin
                r = a * b; o = (r > 255); r = r & 255;
            end
        endcase
        return {o, c, (r == 0), r[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: call only at #1 after a rising edge
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int waited, output logic vld_at);
        in_valid    = 1'b1;
        in_function = op;
        in_lhs      = a;
        in_rhs      = b;
        waited      = 0;
        @(negedge clk);
        while (!out_in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        vld_at = out_valid;
        if (!out_in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready never rose, waited %0d cycles", waited);
        end else begin
            exp_q.push_back(model(op, a, b));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, output int rdy_low);
        cycles  = 0;
        rdy_low = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!out_in_ready) rdy_low++;
        end while (!out_valid && cycles < 100);
        if (!out_valid) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [10:0] exp, input int lat);
        int w, cyc, rl;
        logic v;
        send(op, a, b, w, v);
        wait_valid(cyc, rl);
        check({name, "_lat"}, cyc, lat);
        check(name, got_bits(), exp);
        step();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && sink_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no output", got_bits());
            end else begin
                check("sb", got_bits(), exp_q.pop_front());
            end
        end
    end

    // random sink backpressure
    always begin
        @(posedge clk);
        #1;
        if (rand_sink) sink_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int w, cyc, rl, n;
        logic v;
        logic [2:0] op;
        logic [7:0] a, b;

        rst_n = 1'b0; in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_function = '0;
        sink_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_valid", out_valid, 0);
        check("rst_result", {out_overflow, out_carry, out_zero, out_result}, 0);
        check("rst_in_ready", out_in_ready, 1);
        check("rst_state", dbg_state, 0);

        directed("add_carry",  3'd0, 8'hF0, 8'h20, {1'b0, 1'b1, 1'b0, 8'h10}, 1);
        directed("add_ovf",    3'd0, 8'h7F, 8'h01, {1'b1, 1'b0, 1'b0, 8'h80}, 1);
        directed("sub_zero",   3'd1, 8'h05, 8'h05, {1'b0, 1'b0, 1'b1, 8'h00}, 1);
        directed("sub_borrow", 3'd1, 8'h00, 8'h01, {1'b0, 1'b1, 1'b0, 8'hFF}, 1);
        directed("shl_1",      3'd5, 8'h81, 8'h01, {1'b0, 1'b0, 1'b0, 8'h02}, 1);
        directed("shr_9",      3'd6, 8'h80, 8'h09, {1'b0, 1'b0, 1'b1, 8'h00}, 1);
        directed("shl_0",      3'd5, 8'hA5, 8'h00, {1'b0, 1'b0, 1'b0, 8'hA5}, 1);

        send(3'd7, 8'h0C, 8'h0B, w, v);
        wait_valid(cyc, rl);
        check("mul_latency", cyc, 9);
        check("mul_ready_low", rl, 8);
        check("mul_0c_0b", got_bits(), {1'b0, 1'b0, 1'b0, 8'h84});
        step();
        directed("mul_ovf", 3'd7, 8'h10, 8'h10, {1'b1, 1'b0, 1'b1, 8'h00}, 9);

        // backpressure hold
        sink_ready = 1'b0;
        send(3'd2, 8'hF0, 8'h3C, w, v);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, 8'h30);
            check("hold_in_ready", out_in_ready, 0);
        end
        step();
        sink_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("release_idle_valid", out_valid, 0);
        check("release_idle_state", dbg_state, 0);
        step();

        // back-to-back stream
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: op = 3'd3;
                1: op = 3'd4;
                default: op = 3'd0;
            endcase
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send(op, a, b, w, v);
            check("b2b_wait", w, 0);
            if (i > 0) check("b2b_valid", v, 1);
        end

        // random ops with random backpressure
        rand_sink = 1;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            b  = (op == 3'd5 || op == 3'd6) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 255));
            send(op, a, b, w, v);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_sink = 0;
        sink_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            step();
            n++;
        end
        check("drain_random", exp_q.size(), 0);

        // reset during multiply aborts it
        send(3'd7, 8'hFF, 8'hFF, w, v);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_valid", out_valid, 0);
        check("abort_result", out_result, 0);
        check("abort_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("abort_in_ready", out_in_ready, 1);
        directed("post_reset_add", 3'd0, 8'h12, 8'h34, {1'b0, 1'b0, 1'b0, 8'h46}, 1);
        step();
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_stream.md
Name: alu_stream

Overview:
- Parametrised successor to the team's 8-bit single-cycle ALU.
- Operand width is configurable. Input and output both use a valid/ready handshake, and the result register holds until the consumer accepts it.
- Adds zero, carry and overflow flags, plus an iterative (multi-cycle) unsigned multiply.
- Sits between an operand/decode front end and a result sink that may apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (2..64).
- SHW, $clog2(WIDTH)+1, derived; low bits of in_rhs examined for shift range checks.

Ports:
- in_clock  input  1  single clock; all state updates on rising edge.
- in_reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand/function presented.
- out_in_ready  output  1  block can accept an operation this cycle.
- in_lhs  input  WIDTH  left operand.
- in_rhs  input  WIDTH  right operand / shift amount.
- in_function  input  3  operation code.
- out_valid  output  1  result and flags valid.
- in_out_ready  input  1  sink accepts result this cycle.
- out_result  output  WIDTH  registered result.
- out_zero  output  1  result == 0.
- out_carry  output  1  carry out (ADD) or borrow (SUB); 0 otherwise.
- out_overflow  output  1  signed overflow (ADD/SUB); high product half nonzero (MUL); 0 otherwise.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0; out_result=0; all flags=0; multiplier registers=0.
- Reset asserted mid-multiply or mid-hold aborts the operation; the pending result is discarded.
- Handshake:
  - Input transfer occurs when in_valid && out_in_ready.
  - Output transfer occurs when out_valid && in_out_ready.
  - out_result and flags are stable while out_valid=1 and the sink has not accepted.
- out_in_ready = (state==IDLE) || (state==DONE && in_out_ready). This allows back-to-back ops at one per cycle with no bubble.
- Opcodes:
  - 000 ADD; 001 SUB (lhs-rhs); 010 AND; 011 OR; 100 XOR.
  - 101 SHL; 110 SHR (logical).
  - 111 MUL: unsigned, low WIDTH bits of the product.
- Shifts: amount = full in_rhs value. Amount >= WIDTH gives result 0. Amount 0 gives lhs.
- ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum. Overflow = operands have the same sign and the result sign differs.
- SUB: carry = 1 when lhs < rhs unsigned (borrow). Overflow = operands have different signs and the result sign differs from lhs.
- State machine:
  - IDLE: accept non-MUL → DONE (result registered, out_valid=1 next cycle; latency 1). Accept MUL → MUL.
  - MUL: shift-add, one multiplier bit per cycle, counter 0..WIDTH-1. On the last iteration → DONE. Latency WIDTH+1 cycles from acceptance to out_valid. out_in_ready=0 throughout.
  - DONE: out_valid=1.
    - in_out_ready=0 → stay, hold outputs.
    - in_out_ready=1 and a new op is accepted → handle as in IDLE (DONE again or MUL) in the same edge.
    - in_out_ready=1 and no new op → IDLE, out_valid=0.
- Unsupported encodings: none (all 8 codes are defined).
- Flags are computed from the final WIDTH-bit result and registered with it.
- MUL overflow = upper WIDTH bits of the 2*WIDTH accumulator are nonzero.

Decomposition:
- Package alu_stream_pkg:
  - op code localparams (OP_ADD..OP_MUL);
  - state encoding (ST_IDLE, ST_MUL, ST_DONE);
  - flag bit indices.
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - Ports: start, lhs, rhs, busy, done, product[2*WIDTH-1:0].
  - Same clock and reset.
- Top level holds the FSM, the combinational single-cycle datapath, and the output/flag registers.

Test Plan (WIDTH=8):
- Reset, then ADD 0xF0+0x20 with sink ready → next cycle out_valid=1, result 0x10, carry=1, zero=0, overflow=0. ADD 0x7F+0x01 → 0x80, overflow=1, carry=0.
- SUB 0x05-0x05 → 0x00, zero=1, carry=0. SUB 0x00-0x01 → 0xFF, carry=1. SHL 0x81 by 1 → 0x02. SHR 0x80 by 9 → 0x00, zero=1.
- MUL 0x0C*0x0B → out_valid exactly 9 cycles after acceptance, result 0x84, overflow=0, out_in_ready=0 for 8 cycles. MUL 0x10*0x10 → 0x00, zero=1, overflow=1.
- Backpressure: in_out_ready=0 for 5 cycles after AND 0xF0&0x3C → result 0x30 held stable, out_in_ready=0. Release → transfer, then IDLE.
- Back-to-back: in_valid and in_out_ready held high with OR, XOR, ADD streams → one result per cycle, no bubbles, order preserved.
- Assert in_reset_n=0 asynchronously during MUL cycle 4 → out_valid=0, result 0 immediately. After release, out_in_ready=1 and the next ADD completes normally.
